// File: rtl/ahb_sensor_array.sv
// AHB-Lite zero-wait slave that counts and times falling edges on CHANNELS active-low sensor inputs.
// Optional per-channel glitch filter: define SENSOR_DEBOUNCE_EN (length DEBOUNCE_CYCLES).

module ahb_sensor_chan #(
  parameter int COUNT_WIDTH     = 16,
  parameter int PERIOD_WIDTH    = 24,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                    gclk,
  input  logic                    grst_n,
  input  logic                    n_sensor,
  input  logic                    enable,
  input  logic                    count_clr,
  output logic [COUNT_WIDTH-1:0]  count,
  output logic [PERIOD_WIDTH-1:0] period,
  output logic                    period_evt
);
  localparam logic [PERIOD_WIDTH-1:0] PMAX = '1;

  logic [1:0]              sync_q;
  logic                    level, level_q, primed, evt;
  logic [PERIOD_WIDTH-1:0] pcnt;

  always_ff @(posedge gclk or negedge grst_n)
    if (!grst_n) sync_q <= 2'b11;
    else         sync_q <= {sync_q[0], n_sensor};

`ifdef SENSOR_DEBOUNCE_EN
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [DW-1:0] db_cnt;

  // level follows the synchronised input only after it has disagreed for DEBOUNCE_CYCLES in a row
  always_ff @(posedge gclk or negedge grst_n)
    if (!grst_n) begin
      level  <= 1'b1;
      db_cnt <= '0;
    end else if (sync_q[1] == level) begin
      db_cnt <= '0;
    end else if (db_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
      level  <= sync_q[1];
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + DW'(1);
    end
`else
  localparam int unused_debounce = DEBOUNCE_CYCLES;
  assign level = sync_q[1];
`endif

  assign evt        = enable & level_q & ~level;
  assign period_evt = evt & primed;

  always_ff @(posedge gclk or negedge grst_n)
    if (!grst_n) begin
      level_q <= 1'b1;
      primed  <= 1'b0;
      pcnt    <= '0;
      period  <= '0;
      count   <= '0;
    end else begin
      level_q <= level;
      // an event beats a simultaneous clear: the clear lands first, then the increment
      if (evt)            count <= count_clr ? COUNT_WIDTH'(1) : count + COUNT_WIDTH'(1);
      else if (count_clr) count <= '0;
      if (!enable) begin
        primed <= 1'b0;
        pcnt   <= '0;
      end else if (evt) begin
        primed <= 1'b1;
        pcnt   <= '0;
        // +1 counts the event cycle itself so PERIOD equals the edge spacing in cycles
        if (primed) period <= (pcnt == PMAX) ? PMAX : pcnt + PERIOD_WIDTH'(1);
      end else if (pcnt != PMAX) begin
        pcnt <= pcnt + PERIOD_WIDTH'(1);
      end
    end
endmodule

module ahb_sensor_array #(
  parameter int CHANNELS        = 2,
  parameter int COUNT_WIDTH     = 16,
  parameter int PERIOD_WIDTH    = 24,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                HCLK,
  input  logic                HRESETn,
  input  logic                HSEL,
  input  logic                HWRITE,
  input  logic                HREADY,
  input  logic [31:0]         HADDR,
  input  logic [31:0]         HWDATA,
  input  logic [1:0]          HTRANS,
  input  logic [2:0]          HSIZE,
  output logic [31:0]         HRDATA,
  output logic                HREADYOUT,
  input  logic [CHANNELS-1:0] nSensor
);
  typedef struct packed {
    logic [4:0] idx;
    logic       write;
    logic [2:0] size;
  } ahb_req_t;

  ahb_req_t                                ap_q;
  logic                                    ap_vld, wr_en;
  logic [CHANNELS-1:0]                     status, enable, count_clr, period_evt;
  logic [CHANNELS-1:0][COUNT_WIDTH-1:0]    count;
  logic [CHANNELS-1:0][PERIOD_WIDTH-1:0]   period;
  logic [31:0]                             rd_data;
  logic                                    unused_bits;

  assign unused_bits = ^{HADDR[31:7], HADDR[1:0], HTRANS[0], HWDATA};
  assign HREADYOUT   = 1'b1;

  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      ap_vld <= 1'b0;
      ap_q   <= '0;
    end else if (HREADY) begin
      ap_vld <= HSEL & HTRANS[1];
      ap_q   <= '{idx: HADDR[6:2], write: HWRITE, size: HSIZE};
    end

  assign wr_en = ap_vld & ap_q.write & (ap_q.size == 3'b010) & HREADY;

  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      status <= '0;
      enable <= '1;
    end else begin
      if (wr_en && ap_q.idx == 5'd1) enable <= HWDATA[CHANNELS-1:0];
      if (wr_en && ap_q.idx == 5'd0) status <= (status & ~HWDATA[CHANNELS-1:0]) | period_evt;
      else                           status <= status | period_evt;
    end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    assign count_clr[i] = wr_en && (ap_q.idx == 5'(8 + 2*i));
    ahb_sensor_chan #(
      .COUNT_WIDTH    (COUNT_WIDTH),
      .PERIOD_WIDTH   (PERIOD_WIDTH),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_chan (
      .gclk      (HCLK),
      .grst_n    (HRESETn),
      .n_sensor  (nSensor[i]),
      .enable    (enable[i]),
      .count_clr (count_clr[i]),
      .count     (count[i]),
      .period    (period[i]),
      .period_evt(period_evt[i])
    );
  end

  always_comb begin
    rd_data = '0;
    if (ap_q.idx == 5'd0) rd_data[CHANNELS-1:0] = status;
    if (ap_q.idx == 5'd1) rd_data[CHANNELS-1:0] = enable;
    for (int i = 0; i < CHANNELS; i++) begin
      if (ap_q.idx == 5'(8 + 2*i)) rd_data = 32'(count[i]);
      if (ap_q.idx == 5'(9 + 2*i)) rd_data = 32'(period[i]);
    end
  end

  assign HRDATA = (ap_vld && !ap_q.write) ? rd_data : 32'h0;
endmodule

// File: tb/tb_ahb_sensor_array.sv
// Directed bench: dut_a uses default widths, dut_b narrow widths (COUNT 3, PERIOD 4) for wrap/saturation.
module tb_ahb_sensor_array;
`ifdef SENSOR_DEBOUNCE_EN
  localparam int PL = 20, LAT = 19, GLITCH_CNT = 0;
`else
  localparam int PL = 4,  LAT = 3,  GLITCH_CNT = 1;
`endif
  localparam int P_A = 2*PL;
  localparam int P_B = (2*PL > 15) ? 15 : 2*PL;
  localparam logic [31:0] A_STAT = 32'h00, A_EN = 32'h04, A_C0 = 32'h20, A_P0 = 32'h24,
                          A_C1 = 32'h28, A_P1 = 32'h2C;

  logic        HCLK = 1'b0, HRESETn = 1'b0, HSEL = 1'b0, HWRITE = 1'b0, HREADY = 1'b1;
  logic [31:0] HADDR = '0, HWDATA = '0;
  logic [1:0]  HTRANS = 2'b00;
  logic [2:0]  HSIZE = 3'b010;
  logic [1:0]  nSensor = 2'b11;
  logic [31:0] hrdata_a, hrdata_b;
  logic        hready_a, hready_b;
  int checks = 0, failures = 0;

  always #5 HCLK = ~HCLK;

  ahb_sensor_array #(.CHANNELS(2), .DEBOUNCE_CYCLES(16)) dut_a (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HWRITE(HWRITE), .HREADY(HREADY),
    .HADDR(HADDR), .HWDATA(HWDATA), .HTRANS(HTRANS), .HSIZE(HSIZE),
    .HRDATA(hrdata_a), .HREADYOUT(hready_a), .nSensor(nSensor));

  ahb_sensor_array #(.CHANNELS(2), .COUNT_WIDTH(3), .PERIOD_WIDTH(4), .DEBOUNCE_CYCLES(16)) dut_b (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HWRITE(HWRITE), .HREADY(HREADY),
    .HADDR(HADDR), .HWDATA(HWDATA), .HTRANS(HTRANS), .HSIZE(HSIZE),
    .HRDATA(hrdata_b), .HREADYOUT(hready_b), .nSensor(nSensor));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d,
                    input logic [2:0] size = 3'b010, input logic [1:0] trans = 2'b10);
    @(posedge HCLK); #1;
    HSEL = 1'b1; HTRANS = trans; HWRITE = 1'b1; HADDR = a; HSIZE = size;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HSIZE = 3'b010; HWDATA = d;
    @(posedge HCLK); #1;
  endtask

  task automatic rdchk(input string tag, input logic [31:0] a,
                       input logic [31:0] exp_a, input logic [31:0] exp_b);
    @(posedge HCLK); #1;
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = a;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00;
    chk({tag, "_a"}, hrdata_a, exp_a);
    chk({tag, "_b"}, hrdata_b, exp_b);
  endtask

  task automatic pulse(input int ch, input int lo, input int hi);
    nSensor[ch] = 1'b0;
    repeat (lo) @(posedge HCLK);
    #1 nSensor[ch] = 1'b1;
    repeat (hi) @(posedge HCLK);
    #1;
  endtask

  // ch1 falls so that its event lands on the commit edge of the following write
  task automatic collide(input logic [31:0] a, input logic [31:0] d);
    nSensor[1] = 1'b0;
    repeat (LAT - 3) @(posedge HCLK);
    #1 wr(a, d);
    nSensor[1] = 1'b1;
    repeat (PL) @(posedge HCLK);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge HCLK);
    #1;
    chk("rst_hreadyout", {31'b0, hready_a}, 32'h1);
    chk("rst_hrdata", hrdata_a, 32'h0);
    HRESETn = 1'b1;
    rdchk("rst_status", A_STAT, 32'h0, 32'h0);
    rdchk("rst_enable", A_EN, 32'h3, 32'h3);
    rdchk("rst_count0", A_C0, 32'h0, 32'h0);
    rdchk("rst_period0", A_P0, 32'h0, 32'h0);

    // count: five pulses on ch0
    repeat (5) pulse(0, PL, PL);
    rdchk("cnt_count0", A_C0, 32'd5, 32'd5);
    rdchk("cnt_count1", A_C1, 32'd0, 32'd0);
    rdchk("cnt_period0", A_P0, P_A, P_B);
    rdchk("cnt_status", A_STAT, 32'h1, 32'h1);

    // period: 40 then 100 cycle spacing; narrow instance saturates
    wr(A_STAT, 32'h1);
    rdchk("w1c_status", A_STAT, 32'h0, 32'h0);
    repeat (3) pulse(0, PL, 40 - PL);
    rdchk("per40_period0", A_P0, 32'd40, 32'd15);
    rdchk("per40_status", A_STAT, 32'h1, 32'h1);
    repeat (3) pulse(0, PL, 100 - PL);
    rdchk("per100_period0", A_P0, 32'd100, 32'd15);
    rdchk("per100_status", A_STAT, 32'h1, 32'h1);
    wr(A_STAT, 32'h1);
    rdchk("per100_clr", A_STAT, 32'h0, 32'h0);
    rdchk("per_count0", A_C0, 32'd11, 32'd3);

    // wrap: clear then nine events
    wr(A_C0, 32'hDEAD);
    rdchk("clr_count0", A_C0, 32'd0, 32'd0);
    repeat (9) pulse(0, PL, PL);
    rdchk("wrap_count0", A_C0, 32'd9, 32'd1);

    // collisions on ch1: first pulse only primes
    pulse(1, PL, PL);
    rdchk("prime_period1", A_P1, 32'd0, 32'd0);
    wr(A_STAT, 32'h3);
    collide(A_STAT, 32'h2);
    rdchk("col_status", A_STAT, 32'h2, 32'h2);
    rdchk("col_count1_pre", A_C1, 32'd2, 32'd2);
    collide(A_C1, 32'h0);
    rdchk("col_count1", A_C1, 32'd1, 32'd1);

    // ignored writes: byte size and IDLE transfer
    wr(A_EN, 32'h0, 3'b000);
    rdchk("byte_wr_enable", A_EN, 32'h3, 32'h3);
    wr(A_EN, 32'h0, 3'b010, 2'b00);
    rdchk("idle_wr_enable", A_EN, 32'h3, 32'h3);

    // disable ch0
    wr(A_EN, 32'h2);
    rdchk("dis_enable", A_EN, 32'h2, 32'h2);
    repeat (3) pulse(0, PL, PL);
    rdchk("dis_count0", A_C0, 32'd9, 32'd1);
    rdchk("dis_period0", A_P0, P_A, P_B);
    rdchk("dis_status", A_STAT, 32'h2, 32'h2);

    // glitch filter
    wr(A_EN, 32'h3);
    wr(A_C0, 32'h0);
    pulse(0, 10, 30);
    rdchk("glitch_count0", A_C0, GLITCH_CNT, GLITCH_CNT);
    pulse(0, 20, 30);
    rdchk("long_count0", A_C0, GLITCH_CNT + 1, GLITCH_CNT + 1);

    // reset in the data phase of an ENABLE write
    @(posedge HCLK); #1;
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = A_EN; HSIZE = 3'b010;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = 32'h0;
    #2 HRESETn = 1'b0;
    #1;
    chk("midrst_hrdata", hrdata_a, 32'h0);
    chk("midrst_hreadyout", {31'b0, hready_b}, 32'h1);
    repeat (2) @(posedge HCLK);
    #1 HRESETn = 1'b1;
    rdchk("midrst_enable", A_EN, 32'h3, 32'h3);
    rdchk("midrst_count0", A_C0, 32'h0, 32'h0);
    rdchk("midrst_status", A_STAT, 32'h0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
